// File: rtl/nano_viewer_pkg.sv
// Shared definitions for the nano viewer display path: screen encodings used by
// view_state_ctrl and vga_display, plus the DHT11 word layout.
package nano_viewer_pkg;

  typedef enum logic [2:0] {
    READY = 3'd0,
    WAIT1 = 3'd1,
    WAIT2 = 3'd2,
    PRECV = 3'd3,
    GAWE1 = 3'd4,
    GAWE2 = 3'd5,
    GAMED = 3'd6,
    SHOWP = 3'd7
  } view_state_e;

  // Sticky event set; field order is also the arbitration priority (MSB wins).
  typedef struct packed {
    logic back;
    logic over;
    logic pic;
    logic next;
    logic game;
  } view_evt_t;

  // DHT11 word: {hum_int, hum_dec, tem_int, tem_dec}
  localparam int HUM_INT_LSB = 24;
  localparam int HUM_DEC_LSB = 16;
  localparam int TEM_INT_LSB = 8;
  localparam int TEM_DEC_LSB = 0;
  localparam logic [7:0] DHT_LIMIT = 8'd99;

  function automatic logic dht_in_range(input logic [7:0] hum, input logic [7:0] tem);
    return (hum <= DHT_LIMIT) && (tem <= DHT_LIMIT);
  endfunction

endpackage

// File: rtl/view_state_ctrl_if.sv
// Event/status bundle between the event sources and the view sequencer;
// master = event side (keys, sensor, receiver, game), slave = sequencer.
interface view_state_ctrl_if;
  logic        frame_sync;
  logic        key_next;
  logic        key_game;
  logic        key_back;
  logic        picture_ready;
  logic        game_over;
  logic        dht11_valid;
  logic [31:0] dht11_in;
  logic [2:0]  state;
  logic [31:0] dht11_data;
  logic        state_changed;
  logic        err_timeout;

  modport master (
    output frame_sync, key_next, key_game, key_back, picture_ready, game_over,
           dht11_valid, dht11_in,
    input  state, dht11_data, state_changed, err_timeout
  );

  modport slave (
    input  frame_sync, key_next, key_game, key_back, picture_ready, game_over,
           dht11_valid, dht11_in,
    output state, dht11_data, state_changed, err_timeout
  );
endinterface

// File: rtl/frame_timer.sv
// Frame counter for the timed screens: clears on state entry, advances once per
// frame_sync, and flags when it sits on the currently selected terminal value.
module frame_timer #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_hit
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_en)   r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_hit = (r_cnt == i_term);

endmodule

// File: rtl/view_state_ctrl.sv
// Frame-synchronous display sequencer: latches events between frames, commits the
// screen state and the double-buffered DHT11 word only on frame_sync.
module view_state_ctrl
  import nano_viewer_pkg::*;
#(
  parameter int WAIT_FRAMES    = 60,
  parameter int TIMEOUT_FRAMES = 600,
  parameter int CNT_W          = 10
) (
  input  logic               vga_clk,
  input  logic               sys_rst_n,
  view_state_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] WAIT_TERM    = CNT_W'(WAIT_FRAMES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(TIMEOUT_FRAMES - 1);

  view_state_e      r_state;
  view_evt_t        r_pend;
  logic [31:0]      r_shadow;
  logic [31:0]      r_dht;
  logic             r_state_changed;
  logic             r_err;

  view_evt_t        w_pulse;
  view_evt_t        w_evt;
  view_state_e      w_next;
  logic             w_set_err;
  logic             w_clr_err;
  logic             w_timed;
  logic             w_hit;
  logic [CNT_W-1:0] w_term;
  logic             w_dht_ok;

  assign w_pulse = {bus.key_back, bus.game_over, bus.picture_ready, bus.key_next, bus.key_game};
  // A pulse landing on the frame_sync cycle still counts for this frame.
  assign w_evt   = r_pend | w_pulse;

  assign w_timed = (r_state == WAIT1) || (r_state == WAIT2) ||
                   (r_state == GAWE1) || (r_state == GAWE2);
  assign w_term  = (r_state == WAIT2) ? TIMEOUT_TERM : WAIT_TERM;

  frame_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (vga_clk),
    .rst_n  (sys_rst_n),
    .i_clr  (bus.frame_sync && (w_next != r_state)),
    .i_en   (bus.frame_sync && w_timed),
    .i_term (w_term),
    .o_hit  (w_hit)
  );

  always_comb begin
    w_next    = r_state;
    w_set_err = 1'b0;
    w_clr_err = 1'b0;
    if (bus.frame_sync) begin
      if (r_state != READY && w_evt.back) begin
        w_next = READY;
      end else begin
        case (r_state)
          READY: begin
            if (w_evt.next) begin
              w_next    = WAIT1;
              w_clr_err = 1'b1;
            end else if (w_evt.game) begin
              w_next = GAWE1;
            end
          end
          WAIT1: if (w_hit) w_next = WAIT2;
          WAIT2: begin
            if (w_evt.pic) begin
              w_next = PRECV;
            end else if (w_hit) begin
              w_next    = READY;
              w_set_err = 1'b1;
            end
          end
          PRECV: if (w_evt.next) w_next = SHOWP;
          GAWE1: if (w_hit) w_next = GAWE2;
          GAWE2: if (w_hit) w_next = GAMED;
          GAMED: if (w_evt.over) w_next = READY;
          default: ;
        endcase
      end
    end
  end

  assign w_dht_ok = dht_in_range(bus.dht11_in[HUM_INT_LSB +: 8], bus.dht11_in[TEM_INT_LSB +: 8]);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state         <= READY;
      r_pend          <= '0;
      r_shadow        <= '0;
      r_dht           <= '0;
      r_state_changed <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_state_changed <= 1'b0;
      if (bus.frame_sync) begin
        r_pend          <= '0;
        r_dht           <= r_shadow;
        r_state         <= w_next;
        r_state_changed <= (w_next != r_state);
      end else begin
        r_pend <= r_pend | w_pulse;
      end
      if (w_clr_err)      r_err <= 1'b0;
      else if (w_set_err) r_err <= 1'b1;
      // Shadow load wins over nothing: on a frame_sync the old value already went out.
      if (bus.dht11_valid && w_dht_ok) r_shadow <= bus.dht11_in;
    end
  end

  assign bus.state         = r_state;
  assign bus.dht11_data    = r_dht;
  assign bus.state_changed = r_state_changed;
  assign bus.err_timeout   = r_err;

endmodule

// File: tb/tb_view_state_ctrl.sv
// Scoreboard bench: two sequencers (WAIT 3 / WAIT 2, TIMEOUT 4) driven by directed
// frames; each frame pushes the hand-computed post-frame outputs for its monitor.
module tb_view_state_ctrl;

  logic vga_clk;
  logic sys_rst_n;

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  bit          sel;
  logic        fs, kn, kg, kb, pr, go, dv;
  logic [31:0] din;

  localparam bit [5:0] NO = 6'd0, KB = 6'd32, GO = 6'd16, PR = 6'd8,
                       KN = 6'd4, KG = 6'd2, DV = 6'd1;

  view_state_ctrl_if ifa ();
  view_state_ctrl_if ifb ();

  assign ifa.frame_sync    = fs & ~sel;
  assign ifa.key_next      = kn & ~sel;
  assign ifa.key_game      = kg & ~sel;
  assign ifa.key_back      = kb & ~sel;
  assign ifa.picture_ready = pr & ~sel;
  assign ifa.game_over     = go & ~sel;
  assign ifa.dht11_valid   = dv & ~sel;
  assign ifa.dht11_in      = din;
  assign ifb.frame_sync    = fs & sel;
  assign ifb.key_next      = kn & sel;
  assign ifb.key_game      = kg & sel;
  assign ifb.key_back      = kb & sel;
  assign ifb.picture_ready = pr & sel;
  assign ifb.game_over     = go & sel;
  assign ifb.dht11_valid   = dv & sel;
  assign ifb.dht11_in      = din;

  view_state_ctrl #(.WAIT_FRAMES(3), .TIMEOUT_FRAMES(4), .CNT_W(10)) dut_a (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .bus(ifa.slave));
  view_state_ctrl #(.WAIT_FRAMES(2), .TIMEOUT_FRAMES(4), .CNT_W(10)) dut_b (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .bus(ifb.slave));

  typedef struct {
    logic [2:0]  st;
    logic        chg;
    logic        err;
    logic [31:0] dht;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitors: after every frame_sync pop one expectation; otherwise no pulse allowed.
  logic fsa, fsb;
  always @(posedge vga_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin fsa <= 1'b0; fsb <= 1'b0; end
    else begin fsa <= ifa.frame_sync; fsb <= ifb.frame_sync; end

  always @(negedge vga_clk) begin
    exp_t e;
    if (sys_rst_n) begin
      if (fsa) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_queue actual=empty expected=entry");
        end else begin
          e = qa.pop_front();
          chk("a_state", 32'(ifa.state), 32'(e.st));
          chk("a_chg",   32'(ifa.state_changed), 32'(e.chg));
          chk("a_err",   32'(ifa.err_timeout), 32'(e.err));
          chk("a_dht",   ifa.dht11_data, e.dht);
        end
      end else chk("a_chg_idle", 32'(ifa.state_changed), 32'd0);
    end
  end

  always @(negedge vga_clk) begin
    exp_t e;
    if (sys_rst_n) begin
      if (fsb) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_queue actual=empty expected=entry");
        end else begin
          e = qb.pop_front();
          chk("b_state", 32'(ifb.state), 32'(e.st));
          chk("b_chg",   32'(ifb.state_changed), 32'(e.chg));
          chk("b_err",   32'(ifb.err_timeout), 32'(e.err));
          chk("b_dht",   ifb.dht11_data, e.dht);
        end
      end else chk("b_chg_idle", 32'(ifb.state_changed), 32'd0);
    end
  end

  task automatic cyc(input bit f, input bit [5:0] ev);
    fs = f;
    {kb, go, pr, kn, kg, dv} = ev;
    @(negedge vga_clk);
    fs = 1'b0;
    {kb, go, pr, kn, kg, dv} = 6'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, NO);
  endtask

  task automatic frm(input bit [5:0] ev, input logic [2:0] st, input bit chg, input bit err,
                     input logic [31:0] dht);
    exp_t e;
    e.st = st; e.chg = chg; e.err = err; e.dht = dht;
    if (sel) qb.push_back(e); else qa.push_back(e);
    cyc(1'b1, ev);
  endtask

  task automatic frame(input bit [5:0] ev, input logic [2:0] st, input bit chg, input bit err,
                       input logic [31:0] dht);
    frm(ev, st, chg, err, dht);
    idle(3);
  endtask

  initial begin
    sel = 1'b0; din = '0;
    fs = 0; kn = 0; kg = 0; kb = 0; pr = 0; go = 0; dv = 0;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge vga_clk);
    chk("rst_state", 32'(ifa.state), 32'd0);
    chk("rst_dht",   ifa.dht11_data, 32'd0);
    chk("rst_chg",   32'(ifa.state_changed), 32'd0);
    chk("rst_err",   32'(ifa.err_timeout), 32'd0);
    sys_rst_n = 1'b1;
    idle(2);

    // Picture path on A (WAIT_FRAMES=3): mid-frame key_next is held until frame_sync.
    cyc(1'b0, KN); idle(2);
    frame(NO, 3'd1, 1, 0, 32'h0);
    frame(NO, 3'd1, 0, 0, 32'h0);
    frame(NO, 3'd1, 0, 0, 32'h0);
    frame(NO, 3'd2, 1, 0, 32'h0);
    cyc(1'b0, PR); idle(1);
    frame(NO, 3'd3, 1, 0, 32'h0);
    // key_back beats key_next on the same frame_sync.
    frame(KB | KN, 3'd0, 1, 0, 32'h0);
    // A pulse in the cycle right after frame_sync applies at the next one.
    frm(NO, 3'd0, 0, 0, 32'h0);
    cyc(1'b0, KN); idle(2);
    frame(NO, 3'd1, 1, 0, 32'h0);
    frame(KB, 3'd0, 1, 0, 32'h0);
    // Illegal events in READY are discarded.
    frame(KB | PR | GO, 3'd0, 0, 0, 32'h0);

    // DHT11 double buffering on A.
    din = 32'h3C05_1903; cyc(1'b0, DV); idle(1);
    chk("dht_hold", ifa.dht11_data, 32'h0);
    frame(NO, 3'd0, 0, 0, 32'h3C05_1903);
    din = 32'h3C05_7003; cyc(1'b0, DV);
    frame(NO, 3'd0, 0, 0, 32'h3C05_1903);
    din = 32'h6405_1903; cyc(1'b0, DV);
    frame(NO, 3'd0, 0, 0, 32'h3C05_1903);
    din = 32'h6305_6302; cyc(1'b0, DV);
    frame(NO, 3'd0, 0, 0, 32'h6305_6302);
    din = 32'h1000_1500;
    frame(DV, 3'd0, 0, 0, 32'h6305_6302);
    frame(NO, 3'd0, 0, 0, 32'h1000_1500);

    // Timeout on A (TIMEOUT_FRAMES=4), then key_next clears the flag.
    frame(KN, 3'd1, 1, 0, 32'h1000_1500);
    frame(NO, 3'd1, 0, 0, 32'h1000_1500);
    frame(NO, 3'd1, 0, 0, 32'h1000_1500);
    frame(NO, 3'd2, 1, 0, 32'h1000_1500);
    frame(NO, 3'd2, 0, 0, 32'h1000_1500);
    frame(NO, 3'd2, 0, 0, 32'h1000_1500);
    frame(NO, 3'd2, 0, 0, 32'h1000_1500);
    frame(NO, 3'd0, 1, 1, 32'h1000_1500);
    frame(KN, 3'd1, 1, 0, 32'h1000_1500);
    frame(KB, 3'd0, 1, 0, 32'h1000_1500);
    frame(KG | KN, 3'd1, 1, 0, 32'h1000_1500);
    frame(KB, 3'd0, 1, 0, 32'h1000_1500);

    // Game path on B (WAIT_FRAMES=2).
    sel = 1'b1;
    idle(2);
    frame(KG, 3'd4, 1, 0, 32'h0);
    frame(NO, 3'd4, 0, 0, 32'h0);
    frame(NO, 3'd5, 1, 0, 32'h0);
    frame(NO, 3'd5, 0, 0, 32'h0);
    frame(NO, 3'd6, 1, 0, 32'h0);
    frame(KN, 3'd6, 0, 0, 32'h0);
    frame(GO, 3'd0, 1, 0, 32'h0);
    frame(KG, 3'd4, 1, 0, 32'h0);
    frame(NO, 3'd4, 0, 0, 32'h0);
    frame(NO, 3'd5, 1, 0, 32'h0);
    frame(KB, 3'd0, 1, 0, 32'h0);
    // Re-entry restarts the counter: full WAIT_FRAMES again in each timed state.
    frame(KG, 3'd4, 1, 0, 32'h0);
    frame(NO, 3'd4, 0, 0, 32'h0);
    frame(NO, 3'd5, 1, 0, 32'h0);
    frame(NO, 3'd5, 0, 0, 32'h0);
    frame(NO, 3'd6, 1, 0, 32'h0);
    din = 32'h2010_2030; cyc(1'b0, DV);
    frame(NO, 3'd6, 0, 0, 32'h2010_2030);

    // Asynchronous reset mid-frame in GAMED with pending events.
    cyc(1'b0, KG | GO);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(ifb.state), 32'd0);
    chk("mid_rst_dht",   ifb.dht11_data, 32'd0);
    chk("mid_rst_chg",   32'(ifb.state_changed), 32'd0);
    chk("mid_rst_err",   32'(ifb.err_timeout), 32'd0);
    @(negedge vga_clk);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    idle(2);
    frame(NO, 3'd0, 0, 0, 32'h0);

    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
